// File: rtl/ab_input_conditioner.sv
// Two-channel button conditioner: 2-FF synchroniser, 4-state debounce FSM with hold counter,
// registered clean level plus a one-cycle strobe on each accepted rising edge.
module ab_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_pulse,
    output logic b_pulse
);

    typedef enum logic [1:0] {StLow, StWaitHi, StHigh, StWaitLo} state_e;

    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       raw;
    logic [1:0]       s1_q, s2_q;
    state_e           st_q  [2];
    state_e           st_d  [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       lvl_q, lvl_d;
    logic [1:0]       pls_q, pls_d;

    assign raw = {b_raw, a_raw};

    // Channel 0 is A, channel 1 is B; only the second sync stage reaches the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            lvl_q <= '0;
            pls_q <= '0;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= StLow;
                cnt_q[i] <= CntZero;
            end
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            pls_q <= pls_d;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        pls_d = '0;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            case (st_q[i])
                StLow: begin
                    if (s2_q[i]) begin
                        st_d[i]  = StWaitHi;
                        cnt_d[i] = CntOne;
                    end else begin
                        cnt_d[i] = CntZero;
                    end
                end
                StWaitHi: begin
                    if (!s2_q[i]) begin
                        st_d[i]  = StLow;
                        cnt_d[i] = CntZero;
                    end else if (cnt_q[i] == CntMax) begin
                        st_d[i]  = StHigh;
                        cnt_d[i] = CntZero;
                        lvl_d[i] = 1'b1;
                        pls_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHigh: begin
                    if (!s2_q[i]) begin
                        st_d[i]  = StWaitLo;
                        cnt_d[i] = CntOne;
                    end
                end
                StWaitLo: begin
                    if (s2_q[i]) begin
                        st_d[i]  = StHigh;
                        cnt_d[i] = CntZero;
                    end else if (cnt_q[i] == CntMax) begin
                        st_d[i]  = StLow;
                        cnt_d[i] = CntZero;
                        lvl_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    st_d[i]  = StLow;
                    cnt_d[i] = CntZero;
                end
            endcase
        end
    end

    assign a       = lvl_q[0];
    assign b       = lvl_q[1];
    assign a_pulse = pls_q[0];
    assign b_pulse = pls_q[1];

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Directed bench for ab_input_conditioner (DEBOUNCE_CYCLES=4): reset, clean edges, bounce,
// short drop, simultaneous channels and reset during a debounce.
module tb_ab_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic a_raw, b_raw;
    logic a, b, a_pulse, b_pulse;

    int n_checks = 0;
    int n_errors = 0;

    ab_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a      (a),
        .b      (b),
        .a_pulse(a_pulse),
        .b_pulse(b_pulse)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle; outputs then show the state after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // With the input changed before edge k (the first step), level is 0 through step 6
    // and becomes 1 with a pulse at step 7 (edge k+6); pulse drops at step 8.
    task automatic expect_rise(input string tag, input logic do_a, input logic do_b);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (do_a) chk({tag, " a low"}, int'(a), 0);
            if (do_b) chk({tag, " b low"}, int'(b), 0);
        end
        step();
        if (do_a) begin
            chk({tag, " a high"}, int'(a), 1);
            chk({tag, " a_pulse"}, int'(a_pulse), 1);
        end
        if (do_b) begin
            chk({tag, " b high"}, int'(b), 1);
            chk({tag, " b_pulse"}, int'(b_pulse), 1);
        end
        step();
        chk({tag, " a_pulse clear"}, int'(a_pulse), 0);
        chk({tag, " b_pulse clear"}, int'(b_pulse), 0);
    endtask

    // Drop both raw inputs, let them settle low, and verify no pulse on the fall.
    task automatic release_all(input string tag);
        int pulses;
        pulses = 0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(a_pulse) + int'(b_pulse);
        end
        chk({tag, " fall pulses"}, pulses, 0);
        chk({tag, " a fell"}, int'(a), 0);
        chk({tag, " b fell"}, int'(b), 0);
    endtask

    initial begin
        int pulses;

        // 1: reset with both raw inputs high
        reset = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst a", int'(a), 0);
            chk("rst b", int'(b), 0);
            chk("rst a_pulse", int'(a_pulse), 0);
            chk("rst b_pulse", int'(b_pulse), 0);
        end
        reset = 1'b0;
        expect_rise("t1", 1'b1, 1'b1);
        release_all("t1");

        // 2: clean rise on A only
        a_raw = 1'b1;
        expect_rise("t2", 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            pulses += int'(a_pulse);
            chk("t2 b stays low", int'(b), 0);
        end
        chk("t2 extra pulses", pulses, 0);
        chk("t2 a held", int'(a), 1);
        release_all("t2");

        // 3: bounce 1,0,1,0 then steady 1
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            a_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            chk("t3 bounce a low", int'(a), 0);
            pulses += int'(a_pulse);
        end
        a_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t3 settle a low", int'(a), 0);
            pulses += int'(a_pulse);
        end
        step();
        chk("t3 a high", int'(a), 1);
        pulses += int'(a_pulse);
        for (int i = 0; i < 4; i++) begin
            step();
            pulses += int'(a_pulse);
        end
        chk("t3 pulse count", pulses, 1);

        // 4: three-cycle drop while a=1 is rejected
        pulses = 0;
        a_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4 a held (drop)", int'(a), 1);
            pulses += int'(a_pulse);
        end
        a_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4 a held (restore)", int'(a), 1);
            pulses += int'(a_pulse);
        end
        chk("t4 pulse count", pulses, 0);
        release_all("t4");

        // 5: simultaneous rise
        a_raw = 1'b1;
        b_raw = 1'b1;
        expect_rise("t5", 1'b1, 1'b1);
        release_all("t5");

        // 6: reset in WAIT_HI with cnt=2, raw kept high through reset
        a_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6 pre-reset a low", int'(a), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6 rst a", int'(a), 0);
            chk("t6 rst a_pulse", int'(a_pulse), 0);
        end
        reset = 1'b0;
        expect_rise("t6", 1'b1, 1'b0);
        chk("t6 b stays low", int'(b), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
